// File: rtl/xoodyak_aead_core_if.sv
`default_nettype none
// ============================================================================
// Module      : xoodyak_aead_core_if
// Description : Host-side operand/result bundle for the Xoodyak AEAD core.
// Revision    : 1.0 - initial release
// ============================================================================
interface xoodyak_aead_core_if;
    logic         start;
    logic [191:0] textin;
    logic [127:0] nonce;
    logic [127:0] assodata;
    logic [127:0] key;
    logic [127:0] verification_data;
    logic         opmode;
    logic [127:0] authdata;
    logic [191:0] textout;
    logic         encdone;
    logic         sqzdone;
    logic         verify;

    modport master (
        output start, textin, nonce, assodata, key, verification_data, opmode,
        input  authdata, textout, encdone, sqzdone, verify
    );

    modport slave (
        input  start, textin, nonce, assodata, key, verification_data, opmode,
        output authdata, textout, encdone, sqzdone, verify
    );
endinterface
`default_nettype wire

// File: rtl/xoodyak_aead_core.sv
`default_nettype none
// ============================================================================
// Module      : xoodyak_aead_core
// Description : Single-block Xoodyak AEAD (Cyclist keyed mode, Xoodoo-384).
//               Define XOODYAK_TWO_ROUND_EN for two rounds per clock.
// Revision    : 1.0 - initial release
// ============================================================================
module xoodyak_aead_core (
    input wire                 eph1,
    input wire                 reset,
    xoodyak_aead_core_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PERM1 = 3'd1,
        ST_PERM2 = 3'd2,
        ST_PERM3 = 3'd3,
        ST_PERM4 = 3'd4
    } state_t;

`ifdef XOODYAK_TWO_ROUND_EN
    localparam logic [3:0] c_last_step = 4'd5;
`else
    localparam logic [3:0] c_last_step = 4'd11;
`endif

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] round_const(input logic [3:0] idx);
        case (idx)
            4'd0:    return 32'h058;
            4'd1:    return 32'h038;
            4'd2:    return 32'h3C0;
            4'd3:    return 32'h0D0;
            4'd4:    return 32'h120;
            4'd5:    return 32'h014;
            4'd6:    return 32'h060;
            4'd7:    return 32'h02C;
            4'd8:    return 32'h380;
            4'd9:    return 32'h0F0;
            4'd10:   return 32'h1A0;
            4'd11:   return 32'h012;
            default: return 32'h000;
        endcase
    endfunction

    // Bus byte 0 is the MSB byte; state byte j lives at bits [8j+7:8j].
    function automatic logic [127:0] swap128(input logic [127:0] v);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = v[127-8*i -: 8];
        return r;
    endfunction

    function automatic logic [191:0] swap192(input logic [191:0] v);
        logic [191:0] r;
        for (int i = 0; i < 24; i++) r[8*i +: 8] = v[191-8*i -: 8];
        return r;
    endfunction

    function automatic logic [383:0] xoodoo_round(input logic [383:0] s, input logic [31:0] rc);
        logic [31:0]  a [3][4];
        logic [31:0]  b [3][4];
        logic [31:0]  p [4];
        logic [31:0]  e [4];
        logic [383:0] r;
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 4; x++)
                a[y][x] = s[32*(4*y+x) +: 32];
        for (int x = 0; x < 4; x++) p[x] = a[0][x] ^ a[1][x] ^ a[2][x];
        for (int x = 0; x < 4; x++) e[x] = rotl(p[(x+3)%4], 5) ^ rotl(p[(x+3)%4], 14);
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 4; x++)
                a[y][x] = a[y][x] ^ e[x];
        for (int x = 0; x < 4; x++) begin
            b[0][x] = a[0][x];
            b[1][x] = a[1][(x+3)%4];
            b[2][x] = rotl(a[2][x], 11);
        end
        b[0][0] = b[0][0] ^ rc;
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 4; x++)
                a[y][x] = b[y][x] ^ (~b[(y+1)%3][x] & b[(y+2)%3][x]);
        for (int x = 0; x < 4; x++) begin
            r[32*x +: 32]     = a[0][x];
            r[32*(4+x) +: 32] = rotl(a[1][x], 1);
            r[32*(8+x) +: 32] = rotl(a[2][(x+2)%4], 8);
        end
        return r;
    endfunction

    state_t         r_st;
    state_t         w_st_next;
    logic [3:0]     r_cnt;
    logic [383:0]   r_state;
    logic [127:0]   r_nonce;
    logic [127:0]   r_ad;
    logic [191:0]   r_text;
    logic [127:0]   r_vdata;
    logic           r_op;
    logic [191:0]   r_textout;
    logic [127:0]   r_authdata;
    logic           r_verify;
    logic           r_encdone;
    logic           r_sqzdone;

    logic           w_last;
    logic [383:0]   w_init;
    logic [383:0]   w_perm;
    logic [383:0]   w_post;
    logic [191:0]   w_out_le;
    logic [191:0]   w_pin;

    assign w_last = (r_cnt == c_last_step);

    // Down(key || 0x00) with cD = 0x02 into an all-zero state.
    assign w_init = {8'h02, 232'd0, 8'h01, 8'h00, swap128(bus.key)};

`ifdef XOODYAK_TWO_ROUND_EN
    logic [3:0] w_rc_idx0;
    logic [3:0] w_rc_idx1;
    assign w_rc_idx0 = r_cnt << 1;
    assign w_rc_idx1 = (r_cnt << 1) | 4'd1;
    assign w_perm    = xoodoo_round(xoodoo_round(r_state, round_const(w_rc_idx0)),
                                    round_const(w_rc_idx1));
`else
    assign w_perm    = xoodoo_round(r_state, round_const(r_cnt));
`endif

    always_ff @(posedge eph1) begin
        if (reset) r_st <= ST_IDLE;
        else       r_st <= w_st_next;
    end

    always_comb begin
        w_st_next = r_st;
        case (r_st)
            ST_IDLE:  if (bus.start) w_st_next = ST_PERM1;
            ST_PERM1: if (w_last)    w_st_next = ST_PERM2;
            ST_PERM2: if (w_last)    w_st_next = ST_PERM3;
            ST_PERM3: if (w_last)    w_st_next = ST_PERM4;
            ST_PERM4: if (w_last)    w_st_next = ST_IDLE;
            default:                 w_st_next = ST_IDLE;
        endcase
    end

    // Absorb/crypt transform applied to the permutation output on the last step.
    always_comb begin
        w_post   = w_perm;
        w_out_le = swap192(r_text) ^ w_perm[191:0];
        w_pin    = r_op ? w_out_le : swap192(r_text);
        case (r_st)
            ST_PERM1: begin
                w_post[127:0]   = w_perm[127:0] ^ swap128(r_nonce);
                w_post[135:128] = w_perm[135:128] ^ 8'h01;
                w_post[383:376] = w_perm[383:376] ^ 8'h03;
            end
            ST_PERM2: begin
                w_post[127:0]   = w_perm[127:0] ^ swap128(r_ad);
                w_post[135:128] = w_perm[135:128] ^ 8'h01;
                w_post[383:376] = w_perm[383:376] ^ 8'h83;
            end
            ST_PERM3: begin
                w_post[191:0]   = w_perm[191:0] ^ w_pin;
                w_post[199:192] = w_perm[199:192] ^ 8'h01;
                w_post[383:376] = w_perm[383:376] ^ 8'h40;
            end
            default: ;
        endcase
    end

    always_ff @(posedge eph1) begin
        if (reset) begin
            r_cnt      <= 4'd0;
            r_state    <= '0;
            r_nonce    <= '0;
            r_ad       <= '0;
            r_text     <= '0;
            r_vdata    <= '0;
            r_op       <= 1'b0;
            r_textout  <= '0;
            r_authdata <= '0;
            r_verify   <= 1'b0;
            r_encdone  <= 1'b0;
            r_sqzdone  <= 1'b0;
        end else begin
            r_encdone <= 1'b0;
            r_sqzdone <= 1'b0;
            if (r_st == ST_IDLE) begin
                if (bus.start) begin
                    r_state    <= w_init;
                    r_cnt      <= 4'd0;
                    r_nonce    <= bus.nonce;
                    r_ad       <= bus.assodata;
                    r_text     <= bus.textin;
                    r_vdata    <= bus.verification_data;
                    r_op       <= bus.opmode;
                    r_textout  <= '0;
                    r_authdata <= '0;
                    r_verify   <= 1'b0;
                end
            end else begin
                r_state <= w_last ? w_post : w_perm;
                r_cnt   <= w_last ? 4'd0 : r_cnt + 4'd1;
                if (w_last && r_st == ST_PERM3) begin
                    r_textout <= swap192(w_out_le);
                    r_encdone <= 1'b1;
                end
                if (w_last && r_st == ST_PERM4) begin
                    r_authdata <= swap128(w_perm[127:0]);
                    r_verify   <= r_op & (w_perm[127:0] == swap128(r_vdata));
                    r_sqzdone  <= 1'b1;
                end
            end
        end
    end

    assign bus.textout  = r_textout;
    assign bus.authdata = r_authdata;
    assign bus.verify   = r_verify;
    assign bus.encdone  = r_encdone;
    assign bus.sqzdone  = r_sqzdone;

endmodule
`default_nettype wire

// File: tb/tb_xoodyak_aead_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_xoodyak_aead_core
// Description : Self-checking bench: byte-level Cyclist/Xoodoo reference model,
//               KAT, loopback, tamper, abort and randomized operations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xoodyak_aead_core;

`ifdef XOODYAK_TWO_ROUND_EN
    localparam int ENC_EDGE = 18;
    localparam int SQZ_EDGE = 24;
`else
    localparam int ENC_EDGE = 36;
    localparam int SQZ_EDGE = 48;
`endif
    localparam int BUDGET = 70;
    localparam logic [31:0] RC_TAB [12] = '{32'h058, 32'h038, 32'h3C0, 32'h0D0, 32'h120, 32'h014,
                                            32'h060, 32'h02C, 32'h380, 32'h0F0, 32'h1A0, 32'h012};

    logic eph1  = 1'b0;
    logic reset = 1'b1;
    int   n_total = 0;
    int   n_bad   = 0;

    always #5 eph1 = ~eph1;

    xoodyak_aead_core_if bus ();

    xoodyak_aead_core dut (
        .eph1  (eph1),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model: state as 48 bytes ----------------
    logic [7:0]  ms [48];
    logic [31:0] ma [3][4];

    function automatic logic [31:0] rl(input logic [31:0] x, input int v);
        if (v == 0) return x;
        return (x << v) | (x >> (32 - v));
    endfunction

    // Plane y <<< (t,v): bit at (x,z) moves to (x+t, z+v).
    task automatic shift_plane(input int y, input int t, input int v);
        logic [31:0] tmp [4];
        for (int x = 0; x < 4; x++) tmp[(x + t) % 4] = rl(ma[y][x], v);
        for (int x = 0; x < 4; x++) ma[y][x] = tmp[x];
    endtask

    task automatic model_perm();
        logic [31:0] p [4];
        logic [31:0] e [4];
        logic [31:0] b [3][4];
        for (int l = 0; l < 12; l++)
            ma[l/4][l%4] = {ms[4*l+3], ms[4*l+2], ms[4*l+1], ms[4*l]};
        for (int r = 0; r < 12; r++) begin
            for (int x = 0; x < 4; x++) p[x] = ma[0][x] ^ ma[1][x] ^ ma[2][x];
            for (int x = 0; x < 4; x++) e[(x + 1) % 4] = rl(p[x], 5) ^ rl(p[x], 14);
            for (int y = 0; y < 3; y++)
                for (int x = 0; x < 4; x++) ma[y][x] ^= e[x];
            shift_plane(1, 1, 0);
            shift_plane(2, 0, 11);
            ma[0][0] ^= RC_TAB[r];
            for (int y = 0; y < 3; y++)
                for (int x = 0; x < 4; x++) b[y][x] = ~ma[(y + 1) % 3][x] & ma[(y + 2) % 3][x];
            for (int y = 0; y < 3; y++)
                for (int x = 0; x < 4; x++) ma[y][x] ^= b[y][x];
            shift_plane(1, 0, 1);
            shift_plane(2, 2, 8);
        end
        for (int l = 0; l < 12; l++)
            for (int k = 0; k < 4; k++) ms[4*l+k] = ma[l/4][l%4][8*k +: 8];
    endtask

    task automatic model_run(input logic op, input logic [127:0] k, input logic [127:0] n,
                             input logic [127:0] a, input logic [191:0] t, input logic [127:0] vd,
                             output logic [191:0] t_o, output logic [127:0] tag_o, output logic ver_o);
        logic [7:0] tb8;
        logic [7:0] o;
        for (int i = 0; i < 48; i++) ms[i] = 8'h00;
        for (int i = 0; i < 16; i++) ms[i] = k[127-8*i -: 8];
        ms[17] = 8'h01;
        ms[47] = 8'h02;
        model_perm();
        for (int i = 0; i < 16; i++) ms[i] ^= n[127-8*i -: 8];
        ms[16] ^= 8'h01;
        ms[47] ^= 8'h03;
        model_perm();
        for (int i = 0; i < 16; i++) ms[i] ^= a[127-8*i -: 8];
        ms[16] ^= 8'h01;
        ms[47] ^= 8'h03;
        ms[47] ^= 8'h80;
        model_perm();
        for (int i = 0; i < 24; i++) begin
            tb8 = t[191-8*i -: 8];
            o   = tb8 ^ ms[i];
            t_o[191-8*i -: 8] = o;
            ms[i] ^= op ? o : tb8;
        end
        ms[24] ^= 8'h01;
        ms[47] ^= 8'h40;
        model_perm();
        for (int i = 0; i < 16; i++) tag_o[127-8*i -: 8] = ms[i];
        ver_o = op && (tag_o == vd);
    endtask

    // ---------------- stimulus ----------------
    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [191:0] rnd192();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    // Starts one operation from the current (idle) cycle; inputs are scrambled after capture.
    task automatic run_op(input logic op, input logic [127:0] k, input logic [127:0] n,
                          input logic [127:0] a, input logic [191:0] t, input logic [127:0] vd,
                          input bit glitch, input int rst_at,
                          output logic [191:0] txt, output logic [127:0] tag, output logic ver,
                          output int enc_e, output int sqz_e, output int n_enc, output int n_sqz);
        bus.key = k;  bus.nonce = n;  bus.assodata = a;  bus.textin = t;
        bus.verification_data = vd;  bus.opmode = op;  bus.start = 1'b1;
        @(posedge eph1);
        #1;
        bus.start = 1'b0;
        bus.key = rnd128();  bus.nonce = rnd128();  bus.assodata = rnd128();
        bus.textin = rnd192();  bus.verification_data = rnd128();  bus.opmode = ~op;
        enc_e = -1;  sqz_e = -1;  n_enc = 0;  n_sqz = 0;
        txt = '0;  tag = '0;  ver = 1'b0;
        for (int e = 1; e <= BUDGET; e++) begin
            bus.start = glitch && (e == 5 || e == 20);
            reset     = (e == rst_at);
            @(posedge eph1);
            #1;
            if (bus.encdone) begin n_enc++; enc_e = e; txt = bus.textout; end
            if (bus.sqzdone) begin
                n_sqz++; sqz_e = e; tag = bus.authdata; ver = bus.verify;
                if (rst_at == 0 && !glitch) break;
            end
        end
        bus.start = 1'b0;
        reset     = 1'b0;
    endtask

    initial begin
        logic [127:0] kk, nn, aa, vd, tg1, mtag, rtag;
        logic [191:0] pt, ct1, mtxt, rtxt;
        logic         mver, rver, op;
        int           ee, se, ne, ns;

        bus.start = 1'b0;  bus.opmode = 1'b0;
        bus.key = '0;  bus.nonce = '0;  bus.assodata = '0;
        bus.textin = '0;  bus.verification_data = '0;

        repeat (3) @(posedge eph1);
        #1;
        chk("rst_textout",  bus.textout, '0);
        chk("rst_authdata", 192'(bus.authdata), '0);
        chk("rst_verify",   192'(bus.verify), '0);
        chk("rst_encdone",  192'(bus.encdone), '0);
        chk("rst_sqzdone",  192'(bus.sqzdone), '0);
        reset = 1'b0;

        // KAT encrypt
        kk = 128'h303132333435363738393a3b3c3d3e3f;
        nn = 128'h4142434445464748494a4b4c4d4e4f50;
        aa = 128'h6162636465666768696a6b6c6d6e6f70;
        pt = 192'h4142434445464748494a4b4c4d4e4f505152535455565758;
        model_run(1'b0, kk, nn, aa, pt, '0, mtxt, mtag, mver);
        run_op(1'b0, kk, nn, aa, pt, '0, 1'b0, 0, rtxt, rtag, rver, ee, se, ne, ns);
        chk("kat_text",   rtxt, mtxt);
        chk("kat_tag",    192'(rtag), 192'(mtag));
        chk("kat_verify", 192'(rver), '0);
        chk("kat_enc_edge", 192'(ee), 192'(ENC_EDGE));
        chk("kat_sqz_edge", 192'(se), 192'(SQZ_EDGE));
        ct1 = rtxt;
        tg1 = rtag;

        // Loopback decrypt, started in the sqzdone cycle
        run_op(1'b1, kk, nn, aa, ct1, tg1, 1'b0, 0, rtxt, rtag, rver, ee, se, ne, ns);
        chk("loop_text",   rtxt, pt);
        chk("loop_tag",    192'(rtag), 192'(tg1));
        chk("loop_verify", 192'(rver), 192'(1'b1));
        chk("loop_enc_edge", 192'(ee), 192'(ENC_EDGE));
        chk("loop_sqz_edge", 192'(se), 192'(SQZ_EDGE));

        // Tamper
        run_op(1'b1, kk, nn, aa, ct1, tg1 ^ 128'h1, 1'b0, 0, rtxt, rtag, rver, ee, se, ne, ns);
        chk("tamper_text",   rtxt, pt);
        chk("tamper_verify", 192'(rver), '0);

        // All-zero encrypt
        model_run(1'b0, '0, '0, '0, '0, '0, mtxt, mtag, mver);
        run_op(1'b0, '0, '0, '0, '0, '0, 1'b0, 0, rtxt, rtag, rver, ee, se, ne, ns);
        chk("zero_text", rtxt, mtxt);
        chk("zero_tag",  192'(rtag), 192'(mtag));

        // Start pulses while busy are ignored
        model_run(1'b0, kk, nn, aa, pt, '0, mtxt, mtag, mver);
        run_op(1'b0, kk, nn, aa, pt, '0, 1'b1, 0, rtxt, rtag, rver, ee, se, ne, ns);
        chk("busy_n_enc",    192'(ne), 192'(1));
        chk("busy_n_sqz",    192'(ns), 192'(1));
        chk("busy_enc_edge", 192'(ee), 192'(ENC_EDGE));
        chk("busy_sqz_edge", 192'(se), 192'(SQZ_EDGE));
        chk("busy_text",     rtxt, mtxt);
        chk("busy_tag",      192'(rtag), 192'(mtag));

        // Reset mid-operation aborts
        run_op(1'b0, kk, nn, aa, pt, '0, 1'b0, ENC_EDGE - 6, rtxt, rtag, rver, ee, se, ne, ns);
        chk("abort_n_enc",    192'(ne), '0);
        chk("abort_n_sqz",    192'(ns), '0);
        chk("abort_textout",  bus.textout, '0);
        chk("abort_authdata", 192'(bus.authdata), '0);
        chk("abort_verify",   192'(bus.verify), '0);

        // Randomized operations
        for (int it = 0; it < 6; it++) begin
            op = 1'($urandom_range(0, 1));
            kk = rnd128();  nn = rnd128();  aa = rnd128();  pt = rnd192();
            if (op == 1'b0) begin
                model_run(1'b0, kk, nn, aa, pt, '0, mtxt, mtag, mver);
                run_op(1'b0, kk, nn, aa, pt, rnd128(), 1'b0, 0, rtxt, rtag, rver, ee, se, ne, ns);
                chk("rnd_enc_text",   rtxt, mtxt);
                chk("rnd_enc_tag",    192'(rtag), 192'(mtag));
                chk("rnd_enc_verify", 192'(rver), '0);
            end else begin
                model_run(1'b0, kk, nn, aa, pt, '0, ct1, tg1, mver);
                vd = ($urandom_range(0, 1) == 1) ? tg1 : (tg1 ^ (128'h1 << $urandom_range(0, 127)));
                model_run(1'b1, kk, nn, aa, ct1, vd, mtxt, mtag, mver);
                run_op(1'b1, kk, nn, aa, ct1, vd, 1'b0, 0, rtxt, rtag, rver, ee, se, ne, ns);
                chk("rnd_dec_text",   rtxt, pt);
                chk("rnd_dec_model",  rtxt, mtxt);
                chk("rnd_dec_tag",    192'(rtag), 192'(tg1));
                chk("rnd_dec_verify", 192'(rver), 192'(vd == tg1));
            end
            chk("rnd_sqz_edge", 192'(se), 192'(SQZ_EDGE));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/xoodyak_aead_core.md
Name: xoodyak_aead_core

Overview:
- Single-block Xoodyak AEAD engine: Cyclist keyed mode over the 384-bit Xoodoo permutation.
- Operands are fixed-size: 128-bit key, 128-bit nonce, 128-bit associated data and 192-bit text (exactly one 24-byte Rkout block).
- Encrypts (opmode=0) or decrypts and verifies (opmode=1), producing text plus a 128-bit tag.
- Sits behind a host that presents all operands with a one-cycle start pulse.

Parameters:
- none; all widths are fixed by the algorithm.

Ports:
- eph1  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle request; honoured only in IDLE.
- textin  in  192  plaintext (opmode=0) or ciphertext (opmode=1).
- nonce  in  128  nonce.
- assodata  in  128  associated data.
- key  in  128  secret key.
- verification_data  in  128  expected tag, used when opmode=1.
- opmode  in  1  0=encrypt, 1=decrypt.
- authdata  out  128  computed tag.
- textout  out  192  ciphertext (encrypt) or plaintext (decrypt).
- encdone  out  1  one-cycle pulse: textout valid.
- sqzdone  out  1  one-cycle pulse: authdata and verify valid.
- verify  out  1  1 = computed tag equals verification_data (decrypt only).

Behaviour:
- Clocking and reset:
  - One clock, eph1; reset is synchronous and active-high.
  - Reset returns the FSM to IDLE and clears state, textout, authdata, verify, encdone and sqzdone to 0.
  - Reset mid-operation aborts with no outputs.
- Byte order:
  - Bus byte 0 is the MSB byte, e.g. key[127:120].
  - State byte j (0..47) occupies lane j/4 at bits [8*(j%4)+7 : 8*(j%4)], i.e. little-endian within each lane.
  - Lane l has plane y=l/4 and column x=l%4.
- Xoodoo round (12 rounds, one per clock):
  - theta: P=A0^A1^A2; E=(P<<<(1,5))^(P<<<(1,14)); Ay^=E.
  - rho-west: A1<<<(1,0); A2<<<(0,11).
  - iota: lane(0,0)^=Ci.
  - chi: Ay^=~A(y+1)&A(y+2).
  - rho-east: A1<<<(0,1); A2<<<(2,8).
  - Notation (t,v) = shift columns by t, rotate lanes left by v.
  - Ci = 058,038,3C0,0D0,120,014,060,02C,380,0F0,1A0,012 (hex).
- On start in IDLE:
  - Capture all inputs and opmode.
  - Load state = Down(key||0x00): bytes 0-15 key, byte 16 = 0x00, byte 17 ^= 0x01, byte 47 ^= 0x02.
  - FSM enters PERM1.
- Permutations: 4 permutations of 12 rounds each. The transform applied on the final round's edge differs per permutation:
  - PERM1 end: Down(nonce, 0x03): bytes 0-15 ^= nonce, byte 16 ^= 0x01, byte 47 ^= 0x03.
  - PERM2 end: Down(AD, 0x03), same layout as PERM1; then byte 47 ^= 0x80 (Up cU for crypt).
  - PERM3 end:
    - Y = bytes 0-23.
    - textout = textin^Y.
    - P = textin (encrypt) or textout value (decrypt).
    - Bytes 0-23 ^= P, byte 24 ^= 0x01.
    - Byte 47 ^= 0x40 (squeeze cU).
    - encdone pulses.
  - PERM4 end:
    - authdata = bytes 0-15.
    - verify = opmode & (bytes 0-15 == verification_data).
    - sqzdone pulses; FSM returns to IDLE.
  - The Up that starts PERM1 and PERM2 uses cU=0x00 (no-op).
- Latency: encdone is high in the cycle after the 36th edge following the start edge; sqzdone after the 48th.
- Output holding:
  - textout, authdata and verify hold until the next accepted start or reset.
  - verify is always 0 in encrypt mode.
- Input rules:
  - start while busy is ignored.
  - Input changes after the capture edge have no effect.
- Back-to-back: start on the sqzdone cycle is accepted, because the FSM is already in IDLE.

Optional Feature:
- Macro XOODYAK_TWO_ROUND_EN.
- Defined: two cascaded rounds per clock, 6 clocks per permutation; encdone at edge 18 and sqzdone at edge 24.
- Undefined: one round per clock (timing above).
- Results are bit-identical either way.

Test Plan:
- KAT encrypt: key=303132333435363738393a3b3c3d3e3f, nonce=4142434445464748494a4b4c4d4e4f50, AD=6162636465666768696a6b6c6d6e6f70, textin=4142434445464748494a4b4c4d4e4f505152535455565758, opmode=0 -> textout/authdata equal the XKCP Xoodyak model for these bytes; encdone at edge 36, sqzdone at 48; verify=0.
- Loopback: second instance with opmode=1, textin=first textout, verification_data=first authdata, start=first sqzdone -> textout=4142…58, authdata equals first tag, verify=1.
- Tamper: same decrypt with verification_data bit 0 flipped -> textout still plaintext, verify=0.
- All-zero key/nonce/AD/text, encrypt -> textout and authdata match the model.
- start pulsed at edges 5 and 20 during a run -> ignored, single encdone/sqzdone at 36/48; reset at edge 30 -> encdone and sqzdone never pulse, outputs read 0.
- With XOODYAK_TWO_ROUND_EN: repeat the KAT -> identical values, encdone at edge 18, sqzdone at 24.
